spi_burst_ram_slave: RTL and testbench
======================================

Name: spi_burst_ram_slave

Overview:
Parametrised successor to the SPI slave/RAM wrapper. It is a serial slave that samples MOSI on every clk rising edge while SS_n is low and owns an internal single-port RAM. It adds configurable address and data widths, back-to-back frames within one SS_n assertion, auto-incrementing write and read pointers with wrap, streaming burst reads, and abort and address-error reporting.

Parameters:
ADDR_SIZE, 8, width of the address payload and of both pointers.
DATA_WIDTH, 8, width of a RAM word and of the data payload.
MEM_DEPTH, 256, number of RAM words; must satisfy MEM_DEPTH <= 2**ADDR_SIZE.
AUTO_INC, 1, 1 = pointers advance after each data word; 0 = pointers hold.

Ports:
clk  in  1  single system clock; all sampling and shifting happen on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
SS_n  in  1  slave select, active low.
MOSI  in  1  serial input, MSB first.
MISO  out  1  serial output, MSB first, registered.
frame_abort  out  1  one-cycle pulse when SS_n rises mid-frame.
addr_err  out  1  one-cycle pulse when an address frame carries a value >= MEM_DEPTH.

Behaviour:
- Reset: state IDLE; wr_addr = 0; rd_addr = 0; shift registers = 0; MISO = 0; frame_abort = 0; addr_err = 0. RAM contents are not cleared. Reset asserted mid-frame discards the frame with no commit and no pulse.
- States: IDLE, CMD, RX, RD_FETCH, RD_SHIFT.
- Sampling: a bit is sampled only on an edge where SS_n is low.
- IDLE -> CMD: on the first edge with SS_n low. No MOSI bit is taken on this edge.
- CMD: samples 2 command bits on consecutive edges. 00 = write address, 01 = write data, 10 = read address, 11 = read data.
  - 00/01/10 -> RX. Payload length is ADDR_SIZE bits for 00/10 and DATA_WIDTH bits for 01.
  - 11 -> RD_FETCH.
- RX commit happens on the edge that samples the last payload bit, using the shift register plus that bit:
  - 00: wr_addr <= payload.
  - 10: rd_addr <= payload.
  - 01: RAM[wr_addr] <= payload, then wr_addr advances (if AUTO_INC).
  - The state returns to CMD on the same edge, so the next frame's first command bit is sampled on the following edge with no gap.
- Address range check: if an address payload is >= MEM_DEPTH, the pointer is unchanged and addr_err pulses on the cycle after the commit edge.
- Pointer advance: if addr == MEM_DEPTH-1 it becomes 0, else addr+1. This applies to non-power-of-2 depths too.
- RD_FETCH (1 cycle): the RAM is read at rd_addr and the word loads into the tx shift register. MISO = 0 during this cycle.
- RD_SHIFT: MISO presents the word MSB first, one bit per cycle, for DATA_WIDTH cycles.
  - MISO updates on the rising edge; the master samples on the next edge.
  - On the edge after the LSB, rd_addr advances (if AUTO_INC) and the state goes to RD_FETCH.
  - Read bursts therefore stream words separated by one 0 gap cycle until SS_n rises.
  - MOSI is ignored in RD_FETCH and RD_SHIFT.
- SS_n high on any edge in CMD, RX, RD_FETCH or RD_SHIFT:
  - state -> IDLE; MISO -> 0; the partial frame is discarded.
  - frame_abort pulses for one cycle if SS_n rose in CMD after at least one command bit, in RX, or in RD_SHIFT mid-word.
  - SS_n rising in CMD before any command bit (IDLE->CMD->IDLE) pulses nothing.
  - SS_n rising in RD_FETCH pulses nothing, and no pointer moves.
- Simultaneous write and read: write data and read data never coexist within one frame. The single RAM port is used by at most one access per cycle.

Decomposition:
- Package spi_burst_pkg holds the state enum (IDLE..RD_SHIFT) and the command codes CMD_WR_ADDR = 2'b00, CMD_WR_DATA = 2'b01, CMD_RD_ADDR = 2'b10, CMD_RD_DATA = 2'b11.
- One sub-module, spi_sp_ram: a single-port RAM with synchronous write and a registered read, parametrised by DATA_WIDTH, ADDR_SIZE and MEM_DEPTH.
- The FSM, counters and pointers stay in the top.

Test Plan:
- Reset then SS_n low, frame 00 + 0xA9, SS_n high -> wr_addr = 0xA9; state IDLE; no pulses.
- One SS_n: 01 + 0x4D, 01 + 0x5E back-to-back -> RAM[0xA9] = 0x4D, RAM[0xAA] = 0x5E, wr_addr = 0xAB.
- wr_addr = 0xFF; two data frames 0x11 and 0x22 -> RAM[0xFF] = 0x11, RAM[0x00] = 0x22, wr_addr = 0x01.
- 10 + 0xA9, then 11, hold SS_n for 2*(DATA_WIDTH+1) cycles -> MISO = 0, 01001101, 0, 01011110; rd_addr = 0xAB.
- SS_n high after 5 payload bits of a 01 frame -> RAM and wr_addr unchanged; frame_abort = 1 for exactly one cycle.
- MEM_DEPTH = 200: frame 00 + 0xC8 -> addr_err pulses and wr_addr is unchanged. Separately, rst_n low mid-burst -> all outputs and pointers at reset values immediately, RAM contents retained.

Source files
------------

// File: rtl/spi_burst_pkg.sv
// Shared FSM encoding and command codes for the burst SPI RAM slave.
package spi_burst_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CMD      = 3'd1,
    RX       = 3'd2,
    RD_FETCH = 3'd3,
    RD_SHIFT = 3'd4
  } state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_sp_ram.sv
// Single-port RAM: synchronous write, registered read, contents never reset.
module spi_sp_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_SIZE  = 8,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [ADDR_SIZE-1:0]  i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      else      o_rdata       <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/spi_burst_ram_slave.sv
// SPI slave with internal RAM: back-to-back frames, auto-increment pointers,
// streaming burst reads, abort and address-range error pulses.
module spi_burst_ram_slave
  import spi_burst_pkg::*;
#(
  parameter int unsigned ADDR_SIZE  = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter bit          AUTO_INC   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic frame_abort,
  output logic addr_err
);

  localparam int unsigned SH_W  = (ADDR_SIZE > DATA_WIDTH) ? ADDR_SIZE : DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(SH_W + 1);
  localparam logic [CNT_W-1:0]   DW_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]   AS_LAST = CNT_W'(ADDR_SIZE - 1);
  localparam logic [ADDR_SIZE:0] DEPTH_C = (ADDR_SIZE + 1)'(MEM_DEPTH);

  state_t                r_state;
  logic [1:0]            r_cmd;
  logic [CNT_W-1:0]      r_cnt;
  logic [SH_W-2:0]       r_rx;
  logic [DATA_WIDTH-1:0] r_tx;
  logic [ADDR_SIZE-1:0]  r_wr_addr, r_rd_addr;
  logic                  r_miso, r_abort, r_addr_err;

  logic [SH_W-1:0]       w_payload;
  logic [ADDR_SIZE-1:0]  w_addr_pl, w_ram_addr;
  logic [DATA_WIDTH-1:0] w_ram_rdata;
  logic [1:0]            w_cmd;
  logic                  w_rx_last, w_addr_ok, w_ram_we, w_rd_start, w_rd_next, w_ram_en;

  function automatic logic [ADDR_SIZE-1:0] f_inc(input logic [ADDR_SIZE-1:0] a);
    return (a == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0 : a + ADDR_SIZE'(1);
  endfunction

  assign w_payload = {r_rx, MOSI};
  assign w_addr_pl = w_payload[ADDR_SIZE-1:0];
  assign w_addr_ok = {1'b0, w_addr_pl} < DEPTH_C;
  assign w_cmd     = {r_cmd[0], MOSI};
  assign w_rx_last = (r_cnt == ((r_cmd == CMD_WR_DATA) ? DW_LAST : AS_LAST));

  // Read is issued on the edge entering RD_FETCH so the word is ready to load
  // into the tx register on the following edge; bursts look ahead one address.
  assign w_ram_we   = !SS_n && (r_state == RX) && w_rx_last && (r_cmd == CMD_WR_DATA);
  assign w_rd_start = !SS_n && (r_state == CMD) && (r_cnt != '0) && (w_cmd == CMD_RD_DATA);
  assign w_rd_next  = !SS_n && (r_state == RD_SHIFT) && (r_cnt == DW_LAST);
  assign w_ram_en   = w_ram_we || w_rd_start || w_rd_next;
  assign w_ram_addr = w_ram_we ? r_wr_addr :
                      (w_rd_next && AUTO_INC) ? f_inc(r_rd_addr) : r_rd_addr;

  spi_sp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_SIZE  (ADDR_SIZE),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_payload[DATA_WIDTH-1:0]),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cmd      <= '0;
      r_cnt      <= '0;
      r_rx       <= '0;
      r_tx       <= '0;
      r_wr_addr  <= '0;
      r_rd_addr  <= '0;
      r_miso     <= 1'b0;
      r_abort    <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_abort    <= 1'b0;
      r_addr_err <= 1'b0;
      if (r_state != IDLE && SS_n) begin
        r_state <= IDLE;
        r_miso  <= 1'b0;
        r_cnt   <= '0;
        r_abort <= ((r_state == CMD) && (r_cnt != '0)) || (r_state == RX) ||
                   ((r_state == RD_SHIFT) && (r_cnt != DW_LAST));
      end else begin
        case (r_state)
          IDLE: if (!SS_n) begin
            r_state <= CMD;
            r_cnt   <= '0;
          end
          CMD: if (r_cnt == '0) begin
            r_cmd[0] <= MOSI;
            r_cnt    <= CNT_W'(1);
          end else begin
            r_cmd   <= w_cmd;
            r_cnt   <= '0;
            r_state <= (w_cmd == CMD_RD_DATA) ? RD_FETCH : RX;
          end
          RX: begin
            r_rx  <= w_payload[SH_W-2:0];
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_rx_last) begin
              r_state <= CMD;
              r_cnt   <= '0;
              case (r_cmd)
                CMD_WR_ADDR: if (w_addr_ok) r_wr_addr <= w_addr_pl; else r_addr_err <= 1'b1;
                CMD_RD_ADDR: if (w_addr_ok) r_rd_addr <= w_addr_pl; else r_addr_err <= 1'b1;
                default:     if (AUTO_INC) r_wr_addr <= f_inc(r_wr_addr);
              endcase
            end
          end
          RD_FETCH: begin
            r_miso  <= w_ram_rdata[DATA_WIDTH-1];
            r_tx    <= {w_ram_rdata[DATA_WIDTH-2:0], 1'b0};
            r_cnt   <= '0;
            r_state <= RD_SHIFT;
          end
          RD_SHIFT: if (r_cnt == DW_LAST) begin
            r_state <= RD_FETCH;
            r_miso  <= 1'b0;
            if (AUTO_INC) r_rd_addr <= f_inc(r_rd_addr);
          end else begin
            r_miso <= r_tx[DATA_WIDTH-1];
            r_tx   <= {r_tx[DATA_WIDTH-2:0], 1'b0};
            r_cnt  <= r_cnt + CNT_W'(1);
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign MISO        = r_miso;
  assign frame_abort = r_abort;
  assign addr_err    = r_addr_err;

endmodule

// File: tb/tb_spi_burst_ram_slave.sv
// Scoreboard bench: a 256-deep and a 200-deep slave share the SPI bus.
module tb_spi_burst_ram_slave;

  logic clk = 1'b0, rst_n = 1'b0, SS_n = 1'b1, MOSI = 1'b0;
  logic miso_a, abort_a, aerr_a, miso_b, abort_b, aerr_b;
  int   n_cmp = 0, n_err = 0;
  logic [7:0] q_exp [$];
  logic [7:0] m_mem [256];
  logic [7:0] m_wr = 8'h00, m_rd = 8'h00;

  always #5 clk = ~clk;

  spi_burst_ram_slave #(.ADDR_SIZE(8), .DATA_WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(miso_a), .frame_abort(abort_a), .addr_err(aerr_a));

  spi_burst_ram_slave #(.ADDR_SIZE(8), .DATA_WIDTH(8), .MEM_DEPTH(200), .AUTO_INC(1'b1)) u_dut200 (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(miso_b), .frame_abort(abort_b), .addr_err(aerr_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      MOSI = v[i];
      @(negedge clk);
    end
  endtask

  task automatic ss_begin();
    SS_n = 1'b0;
    @(negedge clk);
  endtask

  task automatic ss_end();
    SS_n = 1'b1;
    MOSI = 1'b0;
    @(negedge clk);
  endtask

  task automatic frame(input logic [1:0] cmd, input logic [7:0] pl);
    send_bits({6'b0, cmd}, 2);
    send_bits(pl, 8);
  endtask

  task automatic wr_addr(input logic [7:0] a);
    frame(2'b00, a);
    chk("aerr_256", aerr_a, 1'b0);
    m_wr = a;
  endtask

  task automatic wr_data(input logic [7:0] d);
    frame(2'b01, d);
    m_mem[m_wr] = d;
    m_wr = m_wr + 8'd1;
  endtask

  task automatic rd_addr(input logic [7:0] a);
    frame(2'b10, a);
    m_rd = a;
  endtask

  // Pushes expected words, then pops one per streamed word from MISO.
  task automatic rd_burst(input int n, input bit chk200);
    logic [7:0] ga, gb, e;
    send_bits(8'h03, 2);
    for (int w = 0; w < n; w++) begin
      q_exp.push_back(m_mem[m_rd]);
      m_rd = m_rd + 8'd1;
    end
    for (int w = 0; w < n; w++) begin
      e = q_exp.pop_front();
      chk("rd_gap", miso_a, 1'b0);
      for (int b = 0; b < 8; b++) begin
        @(negedge clk);
        ga = {ga[6:0], miso_a};
        gb = {gb[6:0], miso_b};
      end
      chk("rd_word", ga, e);
      if (chk200) chk("rd_word200", gb, e);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal;
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_miso", miso_a, 1'b0);
    chk("rst_abort", abort_a, 1'b0);
    chk("rst_aerr", aerr_a, 1'b0);
    chk("rst_wr", u_dut.r_wr_addr, 8'h00);
    chk("rst_rd", u_dut.r_rd_addr, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    ss_begin(); wr_addr(8'hA9); ss_end();
    chk("wa_ptr", u_dut.r_wr_addr, 8'hA9);
    chk("wa_idle", u_dut.r_state, 3'd0);
    chk("wa_abort", abort_a, 1'b0);

    ss_begin(); wr_data(8'h4D); wr_data(8'h5E); ss_end();
    chk("wd_ptr", u_dut.r_wr_addr, m_wr);

    ss_begin(); wr_addr(8'hFF);
    chk("aerr200_ff", aerr_b, 1'b1);
    wr_data(8'h11); wr_data(8'h22); ss_end();
    chk("wrap_ptr", u_dut.r_wr_addr, 8'h01);

    ss_begin(); rd_addr(8'hA9); rd_burst(2, 1'b0); ss_end();
    chk("rd_ptr", u_dut.r_rd_addr, 8'hAB);
    chk("rd_noabort", abort_a, 1'b0);

    ss_begin(); rd_addr(8'hFF); rd_burst(2, 1'b0); ss_end();

    // Abort inside a data payload after 5 bits.
    ss_begin(); wr_addr(8'hA9);
    send_bits(8'h01, 2); send_bits(8'h15, 5);
    SS_n = 1'b1; MOSI = 1'b0;
    @(negedge clk); chk("abort_rx", abort_a, 1'b1);
    @(negedge clk); chk("abort_1cyc", abort_a, 1'b0);
    chk("abort_ptr", u_dut.r_wr_addr, 8'hA9);

    ss_begin(); send_bits(8'h00, 1); ss_end();
    chk("abort_cmd", abort_a, 1'b1);
    ss_begin(); ss_end();
    chk("noabort_empty", abort_a, 1'b0);

    ss_begin(); rd_addr(8'hA9); send_bits(8'h03, 2);
    repeat (3) @(negedge clk);
    ss_end();
    chk("abort_shift", abort_a, 1'b1);
    chk("abort_rdptr", u_dut.r_rd_addr, 8'hA9);

    ss_begin(); rd_addr(8'hA9); rd_burst(1, 1'b0); ss_end();

    ss_begin(); frame(2'b00, 8'hC8);
    chk("aerr200_c8", aerr_b, 1'b1);
    chk("aerr256_c8", aerr_a, 1'b0);
    @(negedge clk);
    chk("aerr200_1cyc", aerr_b, 1'b0);
    ss_end();
    m_wr = 8'hC8;
    chk("aerr200_ptr", u_dut200.r_wr_addr, 8'hA9);

    ss_begin(); wr_addr(8'hC7); wr_data(8'h77); wr_data(8'h88); ss_end();
    chk("wrap200_ptr", u_dut200.r_wr_addr, 8'h01);
    ss_begin(); rd_addr(8'hC7); rd_burst(2, 1'b1); ss_end();

    // Reset in the middle of a burst read.
    ss_begin(); rd_addr(8'hA9); send_bits(8'h03, 2);
    repeat (4) @(negedge clk);
    rst_n = 1'b0; SS_n = 1'b1;
    #1;
    chk("mrst_miso", miso_a, 1'b0);
    chk("mrst_abort", abort_a, 1'b0);
    chk("mrst_wr", u_dut.r_wr_addr, 8'h00);
    chk("mrst_rd", u_dut.r_rd_addr, 8'h00);
    chk("mrst_state", u_dut.r_state, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_wr = 8'h00; m_rd = 8'h00;
    q_exp.delete();
    @(negedge clk);
    ss_begin(); rd_addr(8'hA9); rd_burst(2, 1'b0); ss_end();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
